cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run/debug controller that sequences the single-cycle CPU core (sccomp/scpu) through a per-cycle execute enable. It supports run, single-step, host halt, PC breakpoint and cycle-limit halts. When halted, it borrows the register-file debug read port (reg_sel/reg_data) and streams all 32 registers to the host over a valid/ready interface.
It sits between the host/bench command interface and the core's clock-enable and debug-read ports.

Parameters:
CNT_W, 32, width of cycle_count
MAX_CYCLES, 1000, cycle limit for RUN; 0 disables the limit

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accept
cmd_op  in  3  0=RUN 1=STEP 2=HALT 3=DUMP 4=CLEAR; 5-7 reserved
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
cpu_pc  in  32  current core PC
cpu_en  out  1  core executes one instruction this cycle
reg_sel  out  5  register-file debug read select
reg_data  in  32  register-file debug read data (combinational from reg_sel)
dump_valid  out  1  dump word valid
dump_ready  in  1  dump word accept
dump_idx  out  5  register index of dump_data
dump_data  out  32  register value
dump_last  out  1  final word of dump
state  out  2  0=IDLE 1=RUN 2=STEP 3=DUMP
halt_cause  out  3  0=NONE 1=HOST 2=BP 3=LIMIT 4=STEP 5=PC
cycle_count  out  CNT_W  number of cpu_en cycles, saturating

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. All state is sampled on the clk rising edge.
- Reset, from any state including mid-dump: state=IDLE, cpu_en=0, cycle_count=0, halt_cause=NONE, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0, dump_last=0. Any pending dump word is dropped.
- Command handshake: a command is accepted when cmd_valid&cmd_ready.
  - cmd_ready=1 in IDLE and RUN; cmd_ready=0 in STEP and DUMP.
  - Reserved opcodes are accepted and ignored.
- IDLE:
  - RUN -> RUN; sets the skip_bp flag.
  - STEP -> STEP.
  - DUMP -> DUMP.
  - CLEAR -> cycle_count=0, halt_cause=NONE.
  - HALT -> no effect.
- RUN:
  - bp_hit = bp_en & (cpu_pc==bp_addr) & ~skip_bp.
  - lim_hit = (MAX_CYCLES!=0) & (cycle_count>=MAX_CYCLES).
  - cpu_en = ~bp_hit & ~lim_hit (combinational).
  - skip_bp clears after the first RUN cycle. Resuming from a breakpoint therefore executes the breakpointed instruction.
  - bp_hit -> IDLE, cause=BP, instruction at bp_addr not executed.
  - Otherwise lim_hit -> IDLE, cause=LIMIT. BP has priority over LIMIT.
  - HALT accepted -> the instruction in that cycle still executes (if cpu_en=1); IDLE next cycle, cause=HOST. A BP or LIMIT hit in the same cycle takes priority over HOST.
  - RUN, STEP, DUMP and CLEAR are ignored while in RUN.
- STEP: cpu_en=1 for exactly one cycle, cycle_count+1, then IDLE with cause=STEP. Breakpoint and limit are not checked.
- cycle_count: increments on every cpu_en=1 cycle and saturates at all-ones.
- DUMP:
  - cpu_en=0 throughout.
  - Per word: drive reg_sel=i. The next cycle, register reg_data into dump_data, set dump_idx=i, assert dump_valid.
  - dump_valid and dump_data are held stable until dump_ready.
  - On the handshake, advance i. The one-cycle bubble between words is permitted.
  - Order is i=0..31; dump_last=1 only with idx 31.
  - After the last handshake -> IDLE next cycle, dump_valid=0. halt_cause and cycle_count are unchanged.
- reg_sel is 0 outside DUMP.
- All comparisons are 32-bit unsigned and equality-only.

Optional Feature:
- Macro: CPU_RUN_CTRL_PC_TRAP_EN.
- With the macro defined: in RUN, if cpu_pc[1:0]!=0 or cpu_pc has any X/Z bit, then cpu_en=0 and the block goes to IDLE with cause=PC.
  - Priority: PC > BP > LIMIT > HOST.
  - The X check uses ^cpu_pc===1'bx and is simulation only.
- Without the macro: no PC check, and cause 5 is never produced.

Test Plan:
- Reset: assert rst for 2 cycles mid-DUMP -> all outputs at reset values next cycle, state=IDLE, dump_valid=0.
- Breakpoint: program PC +4 per instruction from 0, bp_en=1, bp_addr=0x48, RUN -> 18 cpu_en cycles, halt with cpu_pc=0x48, cause=BP, cycle_count=18. Reissue RUN -> executes 0x48 and does not re-halt immediately.
- Limit: bp_en=0, infinite loop, MAX_CYCLES=1000 -> cpu_en falls after exactly 1000 cycles, cause=LIMIT, cycle_count=1000. CLEAR -> count=0, cause=NONE.
- Step/halt: STEP from IDLE -> single cpu_en pulse, count+1, cause=STEP. RUN then HALT 5 cycles later -> 6 cpu_en cycles, cause=HOST.
- Dump: reg model rf[i]=i*0x11111111, dump_ready pseudo-random 1-in-3 -> 32 words, idx 0..31 in order, data exact, dump_last only on idx 31, no drops or duplicates, cmd_ready=0 throughout, cpu_en=0.
- PC trap (macro on): cpu_pc=0x00000042 during RUN -> cpu_en=0 that cycle, cause=PC. With macro off -> run continues.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Host-side command and register-dump handshakes for cpu_run_ctrl.
// master = host/bench, slave = controller.
interface cpu_run_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_last;

    modport master (
        output cmd_valid, cmd_op, dump_ready,
        input  cmd_ready, dump_valid, dump_idx, dump_data, dump_last
    );

    modport slave (
        input  cmd_valid, cmd_op, dump_ready,
        output cmd_ready, dump_valid, dump_idx, dump_data, dump_last
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer and register dumper for the single-cycle core.
// Optional misaligned/unknown PC trap: define CPU_RUN_CTRL_PC_TRAP_EN.
module cpu_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    cpu_run_ctrl_if.slave    bus,
    input  logic             bp_en_i,
    input  logic [31:0]      bp_addr_i,
    input  logic [31:0]      cpu_pc_i,
    output logic             cpu_en_o,
    output logic [4:0]       reg_sel_o,
    input  logic [31:0]      reg_data_i,
    output logic [1:0]       state_o,
    output logic [2:0]       halt_cause_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DUMP = 2'd3
    } state_e;

    localparam logic [2:0] OP_RUN   = 3'd0;
    localparam logic [2:0] OP_STEP  = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_DUMP  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_HOST  = 3'd1;
    localparam logic [2:0] C_BP    = 3'd2;
    localparam logic [2:0] C_LIMIT = 3'd3;
    localparam logic [2:0] C_STEP  = 3'd4;
    localparam logic [2:0] C_PC    = 3'd5;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

    state_e           state_q;
    logic             skip_bp_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       cause_q;
    logic [4:0]       ptr_q;
    logic             dvalid_q;
    logic [4:0]       didx_q;
    logic [31:0]      ddata_q;
    logic             dlast_q;

    logic cmd_ready;
    logic cmd_fire;
    logic bp_hit;
    logic lim_hit;
    logic pc_trap;
    logic cpu_en;

    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign cmd_fire  = bus.cmd_valid && cmd_ready;

    assign bp_hit  = bp_en_i && (cpu_pc_i == bp_addr_i) && !skip_bp_q;
    assign lim_hit = (MAX_CYCLES != 0) && (cnt_q >= MAX_C);

`ifdef CPU_RUN_CTRL_PC_TRAP_EN
    // The X/Z half only has meaning in simulation.
    assign pc_trap = (cpu_pc_i[1:0] != 2'b00) || ((^cpu_pc_i) === 1'bx);
`else
    assign pc_trap = 1'b0;
`endif

    assign cpu_en = ((state_q == S_RUN) && !pc_trap && !bp_hit && !lim_hit)
                 || (state_q == S_STEP);

    assign cnt_d = (cpu_en && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            skip_bp_q <= 1'b0;
            cnt_q     <= '0;
            cause_q   <= C_NONE;
            ptr_q     <= '0;
            dvalid_q  <= 1'b0;
            didx_q    <= '0;
            ddata_q   <= '0;
            dlast_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_RUN: begin
                                state_q   <= S_RUN;
                                skip_bp_q <= 1'b1;
                            end
                            OP_STEP: state_q <= S_STEP;
                            OP_DUMP: begin
                                state_q <= S_DUMP;
                                ptr_q   <= '0;
                            end
                            OP_CLEAR: begin
                                cnt_q   <= '0;
                                cause_q <= C_NONE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    skip_bp_q <= 1'b0;
                    // Trap > breakpoint > limit > host halt.
                    if (pc_trap) begin
                        state_q <= S_IDLE;
                        cause_q <= C_PC;
                    end else if (bp_hit) begin
                        state_q <= S_IDLE;
                        cause_q <= C_BP;
                    end else if (lim_hit) begin
                        state_q <= S_IDLE;
                        cause_q <= C_LIMIT;
                    end else if (cmd_fire && (bus.cmd_op == OP_HALT)) begin
                        state_q <= S_IDLE;
                        cause_q <= C_HOST;
                    end
                end
                S_STEP: begin
                    state_q <= S_IDLE;
                    cause_q <= C_STEP;
                end
                S_DUMP: begin
                    if (!dvalid_q) begin
                        dvalid_q <= 1'b1;
                        ddata_q  <= reg_data_i;
                        didx_q   <= ptr_q;
                        dlast_q  <= (ptr_q == 5'd31);
                    end else if (bus.dump_ready) begin
                        dvalid_q <= 1'b0;
                        dlast_q  <= 1'b0;
                        if (dlast_q) state_q <= S_IDLE;
                        else         ptr_q   <= ptr_q + 5'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.dump_valid = dvalid_q;
    assign bus.dump_idx   = didx_q;
    assign bus.dump_data  = ddata_q;
    assign bus.dump_last  = dlast_q;

    assign cpu_en_o      = cpu_en;
    assign reg_sel_o     = (state_q == S_DUMP) ? ptr_q : 5'd0;
    assign state_o       = state_q;
    assign halt_cause_o  = cause_q;
    assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: halt and dump responses are queued
// by the stimulus and popped by independent monitors.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [1:0]  state;
    logic [2:0]  cause;
    logic [31:0] cnt;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(.CNT_W(32), .MAX_CYCLES(1000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .bp_en_i      (bp_en),
        .bp_addr_i    (bp_addr),
        .cpu_pc_i     (pc),
        .cpu_en_o     (cpu_en),
        .reg_sel_o    (reg_sel),
        .reg_data_i   (reg_data),
        .state_o      (state),
        .halt_cause_o (cause),
        .cycle_count_o(cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Core model: PC advances by 4 per enabled cycle unless frozen.
    logic        pc_ld;
    logic        pc_inc;
    logic [31:0] pc_ld_v;
    int          en_cnt = 0;

    always @(posedge clk) begin
        if (pc_ld) pc <= pc_ld_v;
        else if (cpu_en && pc_inc) pc <= pc + 32'd4;
        if (cpu_en) en_cnt <= en_cnt + 1;
    end

    assign reg_data = 32'(reg_sel) * 32'h11111111;

    typedef struct packed {
        logic [2:0]  cause;
        logic [31:0] cnt;
        logic [31:0] pc;
        logic [31:0] en;
    } halt_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } dw_t;

    halt_t hq[$];
    dw_t   dq[$];
    halt_t hh;
    dw_t   dd;

    task automatic push_halt(input logic [2:0] c, input logic [31:0] n,
                             input logic [31:0] p, input int e);
        halt_t t;
        t.cause = c;
        t.cnt   = n;
        t.pc    = p;
        t.en    = 32'(e);
        hq.push_back(t);
    endtask

    task automatic push_dump;
        dw_t t;
        for (int i = 0; i < 32; i++) begin
            t.idx  = 5'(i);
            t.data = 32'(i) * 32'h11111111;
            t.last = (i == 31);
            dq.push_back(t);
        end
    endtask

    // Halt monitor: fires on every RUN/STEP -> IDLE transition.
    logic [1:0] prev_state;
    always @(negedge clk) begin
        if (rst) begin
            prev_state <= 2'd0;
        end else begin
            if ((prev_state == 2'd1 || prev_state == 2'd2) && state == 2'd0) begin
                if (hq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL halt_unexpected: cause %0d count %0d", cause, cnt);
                end else begin
                    hh = hq.pop_front();
                    chk("halt_cause", 64'(cause), 64'(hh.cause));
                    chk("halt_count", 64'(cnt), 64'(hh.cnt));
                    chk("halt_pc", 64'(pc), 64'(hh.pc));
                    chk("halt_en_cycles", 64'(en_cnt), 64'(hh.en));
                end
            end
            prev_state <= state;
        end
    end

    // Dump monitor.
    logic        pv, pr;
    logic [4:0]  pidx;
    logic [31:0] pdata;
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (state == 2'd3) begin
                chk("dump_cmd_ready", 64'(bus.cmd_ready), 64'd0);
                chk("dump_cpu_en", 64'(cpu_en), 64'd0);
            end
            if (bus.dump_valid) begin
                if (pv && !pr) begin
                    chk("dump_hold_idx", 64'(bus.dump_idx), 64'(pidx));
                    chk("dump_hold_data", 64'(bus.dump_data), 64'(pdata));
                end
                if (bus.dump_ready) begin
                    if (dq.size() == 0) begin
                        total_cnt++;
                        $display("FAIL dump_extra: idx %0d", bus.dump_idx);
                    end else begin
                        dd = dq.pop_front();
                        chk("dump_idx", 64'(bus.dump_idx), 64'(dd.idx));
                        chk("dump_data", 64'(bus.dump_data), 64'(dd.data));
                        chk("dump_last", 64'(bus.dump_last), 64'(dd.last));
                    end
                end
            end
            pv    <= bus.dump_valid;
            pr    <= bus.dump_ready;
            pidx  <= bus.dump_idx;
            pdata <= bus.dump_data;
        end
    end

    // Randomised dump back-pressure, roughly 1-in-3 ready.
    logic rdy_en;
    initial begin
        bus.dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.dump_ready = rdy_en && ($urandom_range(0, 2) == 0);
        end
    end

    task automatic cmd(input logic [2:0] op);
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v, input logic inc);
        pc_ld_v = v;
        pc_ld   = 1'b1;
        @(posedge clk);
        #1;
        pc_ld  = 1'b0;
        pc_inc = inc;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (state != 2'd0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        chk({name, "_idle"}, 64'(state), 64'd0);
        chk({name, "_halt_q_empty"}, 64'(hq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string name);
        @(negedge clk);
        chk({name, "_state"}, 64'(state), 64'd0);
        chk({name, "_cause"}, 64'(cause), 64'd0);
        chk({name, "_count"}, 64'(cnt), 64'd0);
        chk({name, "_cpu_en"}, 64'(cpu_en), 64'd0);
        chk({name, "_reg_sel"}, 64'(reg_sel), 64'd0);
        chk({name, "_dvalid"}, 64'(bus.dump_valid), 64'd0);
        chk({name, "_didx"}, 64'(bus.dump_idx), 64'd0);
        chk({name, "_ddata"}, 64'(bus.dump_data), 64'd0);
        chk({name, "_dlast"}, 64'(bus.dump_last), 64'd0);
        chk({name, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bp_en         = 1'b0;
        bp_addr       = 32'd0;
        pc_ld         = 1'b1;
        pc_ld_v       = 32'd0;
        pc_inc        = 1'b1;
        rdy_en        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        pc_ld = 1'b0;
        chk_reset("reset");

        // Reserved opcode is swallowed.
        cmd(3'd5);
        @(negedge clk);
        chk("reserved_state", 64'(state), 64'd0);
        @(posedge clk);
        #1;

        // Breakpoint at 0x48 after 18 instructions.
        bp_en   = 1'b1;
        bp_addr = 32'h48;
        push_halt(3'd2, 32'd18, 32'h48, 18);
        cmd(3'd0);
        wait_idle(100, "bp");

        // Resume past the breakpoint, host halt in the 6th run cycle.
        push_halt(3'd1, 32'd24, 32'h60, 24);
        cmd(3'd0);
        repeat (5) @(posedge clk);
        #1;
        cmd(3'd2);
        wait_idle(20, "host");

        push_halt(3'd4, 32'd25, 32'h64, 25);
        cmd(3'd1);
        wait_idle(10, "step");

        cmd(3'd4);
        @(negedge clk);
        chk("clear1_count", 64'(cnt), 64'd0);
        chk("clear1_cause", 64'(cause), 64'd0);
        @(posedge clk);
        #1;

        // Cycle limit on a spinning core.
        bp_en = 1'b0;
        set_pc(32'h100, 1'b0);
        push_halt(3'd3, 32'd1000, 32'h100, 1025);
        cmd(3'd0);
        wait_idle(1100, "limit");

        cmd(3'd4);
        @(negedge clk);
        chk("clear2_count", 64'(cnt), 64'd0);
        chk("clear2_cause", 64'(cause), 64'd0);
        @(posedge clk);
        #1;

        // Full register dump under back-pressure.
        push_dump();
        rdy_en = 1'b1;
        cmd(3'd3);
        wait_idle(2000, "dump");
        chk("dump_q_empty", 64'(dq.size()), 64'd0);
        chk("dump_cause_kept", 64'(cause), 64'd0);
        chk("dump_count_kept", 64'(cnt), 64'd0);

        // Reset in the middle of a dump.
        push_dump();
        cmd(3'd3);
        n = 0;
        while (dq.size() > 28 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("middump_progress", 64'(dq.size() <= 28), 64'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        rdy_en = 1'b0;
        dq.delete();
        chk_reset("middump_reset");

        // Misaligned PC during RUN.
        set_pc(32'h42, 1'b0);
`ifdef CPU_RUN_CTRL_PC_TRAP_EN
        push_halt(3'd5, 32'd0, 32'h42, 1025);
        cmd(3'd0);
        wait_idle(10, "pctrap");
`else
        push_halt(3'd1, 32'd6, 32'h42, 1031);
        cmd(3'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("pc_norun_state", 64'(state), 64'd1);
        chk("pc_norun_en", 64'(cpu_en), 64'd1);
        cmd(3'd2);
        wait_idle(20, "pc_norun");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
